ras_shadow_checker: RTL
=======================

# ras_shadow_checker

Return-address checker that sits between the commit stage and the RAS shadow stack. On each committed call it pushes the link address onto the shadow stack. On each committed return it reads the stack top, compares it against the actual return target and pops it. A mismatch raises a sticky control-flow violation and halts checking until software clears it.

## Interface
- ADDR_W, 64, width of return addresses; equals the shadow stack data width.
- CNT_W, 16, width of the unchecked-return and skip counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_call_valid  in  1  committed call; link address on i_call_addr.
- i_call_addr  in  ADDR_W  link address (call PC + instruction length).
- o_call_ready  out  1  call accepted when i_call_valid & o_call_ready.
- i_ret_valid  in  1  committed return; actual target on i_ret_target.
- i_ret_target  in  ADDR_W  actual return target.
- o_ret_ready  out  1  return accepted when i_ret_valid & o_ret_ready.
- o_ss_push  out  1  shadow stack push strobe.
- o_ss_data  out  ADDR_W  shadow stack write data.
- o_ss_pop  out  1  shadow stack pop strobe.
- i_ss_data  in  ADDR_W  shadow stack top; valid one cycle after the stack pointer settles.
- i_ss_full  in  1  shadow stack full.
- i_ss_empty  in  1  shadow stack empty.
- o_viol  out  1  sticky violation flag.
- o_viol_expected  out  ADDR_W  stack value at the violation.
- o_viol_actual  out  ADDR_W  return target at the violation.
- i_viol_clear  in  1  single-cycle clear of o_viol; resumes checking.
- o_unchecked_cnt  out  CNT_W  returns retired without a check; saturating.

## Operation
- FSM states: IDLE, PUSH, WAIT, CMP, VIOL.
- o_call_ready = o_ret_ready = 0 in every state except IDLE.
- **IDLE:** call has priority when both valid, so o_ret_ready = ~i_call_valid.
  - Accepted call → PUSH. The address is latched into o_ss_data.
  - Accepted return with skip_cnt > 0: decrement skip_cnt, increment o_unchecked_cnt, stay IDLE.
  - Accepted return with i_ss_empty: increment o_unchecked_cnt, stay IDLE.
  - Any other accepted return → WAIT. The target is latched.
- **PUSH:** o_ss_push = ~i_ss_full for one cycle, then → IDLE.
  - If i_ss_full, the overflow handling in Configuration applies.
- **WAIT:** one bubble cycle for the BRAM read → CMP.
- **CMP:** o_ss_pop = 1 for one cycle.
  - i_ss_data == latched target → IDLE.
  - Otherwise set o_viol, capture o_viol_expected/o_viol_actual → VIOL.
- **VIOL:** hold all outputs; no stack strobes. i_viol_clear → clear o_viol → IDLE.
- o_unchecked_cnt saturates at all-ones and never wraps. skip_cnt saturates the same way.
- Comparison is full ADDR_W equality.

## Timing
- Reset values: o_call_ready = o_ret_ready = 1, o_ss_push = o_ss_pop = 0, o_ss_data = 0, o_viol = 0, o_viol_expected = o_viol_actual = 0, o_unchecked_cnt = 0, skip_cnt = 0, state IDLE.
- Call accepted at cycle N: o_ss_push high at N+1. Next acceptance possible at N+2.
- Checked return accepted at N: WAIT at N+1; i_ss_data sampled and o_ss_pop high at N+2; o_viol high from N+3 on mismatch. Next acceptance at N+3 on match.
- Unchecked return: zero-bubble, ready stays high.
- i_viol_clear at cycle M in VIOL: o_viol low and ready high at M+1.
- i_viol_clear outside VIOL: ignored.
- rst asserted in any state: all outputs return to reset values next cycle. An in-flight push or pop is abandoned with no strobe issued after reset.
- o_ss_push and o_ss_pop are never high in the same cycle.

## Configuration
- SS_OVERFLOW_TRAP_EN defined: a call arriving in PUSH with i_ss_full sets o_viol with o_viol_expected = 0 and o_viol_actual = call address, then → VIOL.
- SS_OVERFLOW_TRAP_EN undefined: the push is dropped, skip_cnt increments, → IDLE. The next skip_cnt returns are retired unchecked.

## Test plan
- Call 0x1000, then return 0x1000 → one push, pop at return+2, o_viol = 0, o_unchecked_cnt = 0.
- Calls 0xA0, 0xB0; returns 0xB0, 0xC0 → o_viol = 1 at second return+3, o_viol_expected = 0xA0, o_viol_actual = 0xC0; readies low until i_viol_clear.
- Return 0x40 with empty stack → no pop, o_unchecked_cnt = 1, o_ret_ready stays 1.
- Stack full (DEPTH = 8), 9th call 0x900:
  - Macro defined → o_viol = 1, o_viol_actual = 0x900.
  - Macro undefined → no push; the next return is unchecked, the following 8 are checked.
- i_call_valid and i_ret_valid both high in IDLE → only the call is accepted (o_ret_ready = 0); the return is accepted at cycle +2.
- rst pulsed during WAIT → no o_ss_pop is issued, all outputs at reset values, and the next call is pushed normally.

Source files
------------

// File: rtl/ras_shadow_checker_if.sv
// Commit-stage and shadow-stack signal bundle for ras_shadow_checker.
// slave: the checker itself; master: the commit stage / stack / software side.
interface ras_shadow_checker_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 16
);
  logic              i_call_valid;
  logic [ADDR_W-1:0] i_call_addr;
  logic              o_call_ready;
  logic              i_ret_valid;
  logic [ADDR_W-1:0] i_ret_target;
  logic              o_ret_ready;
  logic              o_ss_push;
  logic [ADDR_W-1:0] o_ss_data;
  logic              o_ss_pop;
  logic [ADDR_W-1:0] i_ss_data;
  logic              i_ss_full;
  logic              i_ss_empty;
  logic              o_viol;
  logic [ADDR_W-1:0] o_viol_expected;
  logic [ADDR_W-1:0] o_viol_actual;
  logic              i_viol_clear;
  logic [CNT_W-1:0]  o_unchecked_cnt;

  modport slave (
    input  i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
    input  i_ss_data, i_ss_full, i_ss_empty, i_viol_clear,
    output o_call_ready, o_ret_ready, o_ss_push, o_ss_data, o_ss_pop,
    output o_viol, o_viol_expected, o_viol_actual, o_unchecked_cnt
  );

  modport master (
    output i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
    output i_ss_data, i_ss_full, i_ss_empty, i_viol_clear,
    input  o_call_ready, o_ret_ready, o_ss_push, o_ss_data, o_ss_pop,
    input  o_viol, o_viol_expected, o_viol_actual, o_unchecked_cnt
  );
endinterface

// File: rtl/ras_shadow_checker.sv
// Return-address checker between commit and the RAS shadow stack.
// Calls push the link address; returns compare against the stack top and pop.
// A mismatch latches a sticky violation until software clears it.
// Optional macro SS_OVERFLOW_TRAP_EN: a push into a full stack raises a violation
// instead of being dropped and counted for unchecked retirement.
module ras_shadow_checker #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  ras_shadow_checker_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] CMP  = 3'd3;
  localparam logic [2:0] VIOL = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] call_addr_q, call_addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              viol_q, viol_d;
  logic [ADDR_W-1:0] viol_exp_q, viol_exp_d;
  logic [ADDR_W-1:0] viol_act_q, viol_act_d;
  logic [CNT_W-1:0]  unchecked_q, unchecked_d;
  logic [CNT_W-1:0]  skip_q, skip_d;

  logic idle;
  logic call_fire;
  logic ret_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign idle      = (state_q == IDLE);
  assign call_fire = bus.i_call_valid & bus.o_call_ready;
  assign ret_fire  = bus.i_ret_valid & bus.o_ret_ready;

  // Handshake and stack strobes decode directly from the state register.
  assign bus.o_call_ready    = idle;
  assign bus.o_ret_ready     = idle & ~bus.i_call_valid;
  assign bus.o_ss_push       = (state_q == PUSH) & ~bus.i_ss_full;
  assign bus.o_ss_pop        = (state_q == CMP);
  assign bus.o_ss_data       = call_addr_q;
  assign bus.o_viol          = viol_q;
  assign bus.o_viol_expected = viol_exp_q;
  assign bus.o_viol_actual   = viol_act_q;
  assign bus.o_unchecked_cnt = unchecked_q;

  // Next-state and datapath update for the check sequence.
  always_comb begin
    state_d     = state_q;
    call_addr_d = call_addr_q;
    target_d    = target_q;
    viol_d      = viol_q;
    viol_exp_d  = viol_exp_q;
    viol_act_d  = viol_act_q;
    unchecked_d = unchecked_q;
    skip_d      = skip_q;

    case (state_q)
      IDLE: begin
        if (call_fire) begin
          call_addr_d = bus.i_call_addr;
          state_d     = PUSH;
        end else if (ret_fire) begin
          if (skip_q != '0) begin
            // This return belongs to a call whose push was dropped.
            skip_d      = skip_q - 1'b1;
            unchecked_d = sat_inc(unchecked_q);
          end else if (bus.i_ss_empty) begin
            unchecked_d = sat_inc(unchecked_q);
          end else begin
            target_d = bus.i_ret_target;
            state_d  = WAIT;
          end
        end
      end
      PUSH: begin
        state_d = IDLE;
        if (bus.i_ss_full) begin
`ifdef SS_OVERFLOW_TRAP_EN
          viol_d     = 1'b1;
          viol_exp_d = '0;
          viol_act_d = call_addr_q;
          state_d    = VIOL;
`else
          skip_d = sat_inc(skip_q);
`endif
        end
      end
      WAIT: state_d = CMP;  // stack RAM read latency
      CMP: begin
        if (bus.i_ss_data == target_q) begin
          state_d = IDLE;
        end else begin
          viol_d     = 1'b1;
          viol_exp_d = bus.i_ss_data;
          viol_act_d = target_q;
          state_d    = VIOL;
        end
      end
      VIOL: begin
        if (bus.i_viol_clear) begin
          viol_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any in-flight push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      call_addr_q <= '0;
      target_q    <= '0;
      viol_q      <= 1'b0;
      viol_exp_q  <= '0;
      viol_act_q  <= '0;
      unchecked_q <= '0;
      skip_q      <= '0;
    end else begin
      state_q     <= state_d;
      call_addr_q <= call_addr_d;
      target_q    <= target_d;
      viol_q      <= viol_d;
      viol_exp_q  <= viol_exp_d;
      viol_act_q  <= viol_act_d;
      unchecked_q <= unchecked_d;
      skip_q      <= skip_d;
    end
  end

endmodule
